// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: single-port RAM with a command decoder behind an SPI slave; read data 1 cycle after the read command; no backpressure.
// Optional stored-parity check enabled by the SPI_RAM_PARITY_EN macro.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE+1:0] din,
  input  logic                 rx_valid,
  output logic [ADDR_SIZE-1:0] dout,
  output logic                 tx_valid,
  output logic                 cmd_err,
  output logic                 par_err
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_SIZE:0]   DEPTH_L = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST_A  = ADDR_SIZE'(MEM_DEPTH - 1);
`ifdef SPI_RAM_PARITY_EN
  localparam int MEM_W = ADDR_SIZE + 1;
`else
  localparam int MEM_W = ADDR_SIZE;
`endif

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } op_e;

  logic [MEM_W-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_armed_q, wr_armed_d;
  logic                 rd_armed_q, rd_armed_d;
  logic [ADDR_SIZE-1:0] dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 par_err_q, par_err_d;
  logic                 mem_we;

  op_e                  op;
  logic [ADDR_SIZE-1:0] payload;
  logic                 in_range;
  logic [MEM_W-1:0]     wr_word;
  logic [MEM_W-1:0]     rd_word;

  assign op       = op_e'(din[ADDR_SIZE+1:ADDR_SIZE]);
  assign payload  = din[ADDR_SIZE-1:0];
  assign in_range = ({1'b0, payload} < DEPTH_L);
  assign rd_word  = mem_q[rd_addr_q[IDX_W-1:0]];
`ifdef SPI_RAM_PARITY_EN
  assign wr_word  = {^payload, payload};
`else
  assign wr_word  = payload;
`endif

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_armed_d = wr_armed_q;
    rd_armed_d = rd_armed_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    cmd_err_d  = 1'b0;
    par_err_d  = 1'b0;
    mem_we     = 1'b0;
    if (rx_valid) begin
      case (op)
        OP_WR_ADDR: begin
          if (in_range) begin
            wr_addr_d  = payload;
            wr_armed_d = 1'b1;
          end else begin
            cmd_err_d  = 1'b1;
            wr_armed_d = 1'b0;
          end
        end
        OP_WR_DATA: begin
          if (wr_armed_q) begin
            mem_we    = 1'b1;
            wr_addr_d = (wr_addr_q == LAST_A) ? '0 : wr_addr_q + 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        OP_RD_ADDR: begin
          if (in_range) begin
            rd_addr_d  = payload;
            rd_armed_d = 1'b1;
          end else begin
            cmd_err_d  = 1'b1;
            rd_armed_d = 1'b0;
          end
        end
        OP_RD_DATA: begin
          if (rd_armed_q) begin
            dout_d     = rd_word[ADDR_SIZE-1:0];
            tx_valid_d = 1'b1;
            rd_armed_d = 1'b0;
`ifdef SPI_RAM_PARITY_EN
            par_err_d  = rd_word[ADDR_SIZE] ^ (^rd_word[ADDR_SIZE-1:0]);
`endif
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_armed_q <= 1'b0;
      rd_armed_q <= 1'b0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_armed_q <= wr_armed_d;
      rd_armed_q <= rd_armed_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
      par_err_q  <= par_err_d;
    end
  end

  // Storage is deliberately not reset; reset only suppresses a write in the same cycle.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[wr_addr_q[IDX_W-1:0]] <= wr_word;
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;
  assign par_err  = par_err_q;

endmodule
